// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one external combinational WIDTH-bit multiplier between two
//   requesters. A request is granted round-robin, its operands are latched
//   onto the multiplier for SETTLE cycles, and then the product and overflow
//   flag are captured and returned on a single response port, tagged with
//   the id of the requester that issued it.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   reqN_valid/ready      request handshake, N = 0,1 (ready is combinational)
//   reqN_op1/op2/signed   operands and signedness of requester N
//   mult_op1/op2/signed   latched operands driven to the shared multiplier
//   mult_result, mult_of  multiplier product (low WIDTH bits) and overflow
//   rsp_valid/ready       response handshake
//   rsp_id/result/of      requester id, captured product, captured overflow
module mult_share_arbiter #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1   // 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic             req0_signed,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic             req1_signed,
  output logic [WIDTH-1:0] mult_op1,
  output logic [WIDTH-1:0] mult_op2,
  output logic             mult_signed,
  input  logic [WIDTH-1:0] mult_result,
  input  logic             mult_of,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_of
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic             sgn_q, sgn_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_of_q, rsp_of_d;
  logic             grant;

  // Under contention the requester that did not win last time goes next;
  // otherwise the sole valid requester wins.
  assign grant = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    sgn_d        = sgn_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_of_d     = rsp_of_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // Readies are masked while reset is held so every output reads 0.
          req0_ready   = rst_n & ~grant;
          req1_ready   = rst_n & grant;
          op1_d        = grant ? req1_op1 : req0_op1;
          op2_d        = grant ? req1_op2 : req0_op2;
          sgn_d        = grant ? req1_signed : req0_signed;
          last_grant_d = grant;
          cnt_d        = SETTLE_C;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == 4'd1) begin
          // last_grant still names the requester whose operation is in flight.
          rsp_result_d = mult_result;
          rsp_of_d     = mult_of;
          rsp_id_d     = last_grant_q;
          rsp_valid_d  = 1'b1;
          cnt_d        = 4'd0;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      op1_q        <= '0;
      op2_q        <= '0;
      sgn_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_of_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      sgn_q        <= sgn_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_of_q     <= rsp_of_d;
    end
  end

  assign mult_op1    = op1_q;
  assign mult_op2    = op2_q;
  assign mult_signed = sgn_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_of      = rsp_of_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: one instance with SETTLE=1 (main flows) and
// one with SETTLE=4 (latency and reset-during-ISSUE). Each instance gets its
// own behavioural 8-bit multiplier selected by mult_signed.
module tb_mult_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt = 0;
  int err_cnt = 0;

  // ---------------- instance with SETTLE=1 ----------------
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_signed;
  logic [7:0] req0_op1, req0_op2;
  logic       req1_valid, req1_ready, req1_signed;
  logic [7:0] req1_op1, req1_op2;
  logic [7:0] mult_op1, mult_op2, mult_result;
  logic       mult_signed, mult_of;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_of;
  logic [7:0] rsp_result;

  // ---------------- instance with SETTLE=4 ----------------
  logic       s4_rst_n;
  logic       s4_req0_valid, s4_req0_ready, s4_req0_signed;
  logic [7:0] s4_req0_op1, s4_req0_op2;
  logic       s4_req1_valid, s4_req1_ready, s4_req1_signed;
  logic [7:0] s4_req1_op1, s4_req1_op2;
  logic [7:0] s4_mult_op1, s4_mult_op2, s4_mult_result;
  logic       s4_mult_signed, s4_mult_of;
  logic       s4_rsp_valid, s4_rsp_ready, s4_rsp_id, s4_rsp_of;
  logic [7:0] s4_rsp_result;

  // {overflow, low byte} of an 8x8 multiply.
  function automatic logic [8:0] mul_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic s);
    logic [15:0] p;
    logic        of;
    if (s) begin
      p  = {{8{a[7]}}, a} * {{8{b[7]}}, b};
      of = (p[15:7] != 9'h000) && (p[15:7] != 9'h1FF);
    end else begin
      p  = {8'h00, a} * {8'h00, b};
      of = (p[15:8] != 8'h00);
    end
    return {of, p[7:0]};
  endfunction

  assign {mult_of, mult_result}       = mul_model(mult_op1, mult_op2, mult_signed);
  assign {s4_mult_of, s4_mult_result} = mul_model(s4_mult_op1, s4_mult_op2, s4_mult_signed);

  mult_share_arbiter #(.WIDTH(8), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_signed(req0_signed),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_signed(req1_signed),
    .mult_op1(mult_op1), .mult_op2(mult_op2), .mult_signed(mult_signed),
    .mult_result(mult_result), .mult_of(mult_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_of(rsp_of)
  );

  mult_share_arbiter #(.WIDTH(8), .SETTLE(4)) dut_s4 (
    .clk(clk), .rst_n(s4_rst_n),
    .req0_valid(s4_req0_valid), .req0_ready(s4_req0_ready), .req0_op1(s4_req0_op1),
    .req0_op2(s4_req0_op2), .req0_signed(s4_req0_signed),
    .req1_valid(s4_req1_valid), .req1_ready(s4_req1_ready), .req1_op1(s4_req1_op1),
    .req1_op2(s4_req1_op2), .req1_signed(s4_req1_signed),
    .mult_op1(s4_mult_op1), .mult_op2(s4_mult_op2), .mult_signed(s4_mult_signed),
    .mult_result(s4_mult_result), .mult_of(s4_mult_of),
    .rsp_valid(s4_rsp_valid), .rsp_ready(s4_rsp_ready), .rsp_id(s4_rsp_id),
    .rsp_result(s4_rsp_result), .rsp_of(s4_rsp_of)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // One complete operation from a lone requester with rsp_ready held high.
  task automatic single_op(input logic n, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic [7:0] er, input logic eo);
    if (n) begin
      req1_valid = 1'b1; req1_op1 = a; req1_op2 = b; req1_signed = s;
    end else begin
      req0_valid = 1'b1; req0_op1 = a; req0_op2 = b; req0_signed = s;
    end
    #1;
    check("grant_ready", {30'd0, req1_ready, req0_ready}, n ? 32'd2 : 32'd1);
    cyc;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("issue_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("issue_ops", {15'd0, mult_signed, mult_op1, mult_op2}, {15'd0, s, a, b});
    check("issue_no_rsp", {31'd0, rsp_valid}, 32'd0);
    cyc;
    #1;
    check("rsp", {21'd0, rsp_valid, rsp_id, rsp_of, rsp_result},
          {21'd0, 1'b1, n, eo, er});
    cyc;
    #1;
    check("rsp_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; s4_rst_n = 1'b0;
    rsp_ready = 1'b1; s4_rsp_ready = 1'b1;
    // Both requesters valid from reset: req0 -3*5 signed, req1 64*2 signed.
    req0_valid = 1'b1; req0_op1 = 8'hFD; req0_op2 = 8'h05; req0_signed = 1'b1;
    req1_valid = 1'b1; req1_op1 = 8'h40; req1_op2 = 8'h02; req1_signed = 1'b1;
    s4_req0_valid = 1'b0; s4_req0_op1 = 8'h00; s4_req0_op2 = 8'h00; s4_req0_signed = 1'b0;
    s4_req1_valid = 1'b0; s4_req1_op1 = 8'h00; s4_req1_op2 = 8'h00; s4_req1_signed = 1'b0;
    cyc;
    #1;
    check("reset_outputs",
          {9'd0, mult_op1, mult_op2, mult_signed, rsp_valid, rsp_id, rsp_of, rsp_result[3:0]},
          32'd0);
    check("reset_result", {24'd0, rsp_result}, 32'd0);
    check("reset_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
    cyc;
    rst_n = 1'b1; s4_rst_n = 1'b1;
    #1;

    // Fairness: grants alternate 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      check("fair_grant", {30'd0, req1_ready, req0_ready}, k[0] ? 32'd2 : 32'd1);
      cyc;
      #1;
      check("fair_issue", {22'd0, req1_ready, req0_ready, mult_op1},
            {22'd0, 2'b00, (k[0] ? 8'h40 : 8'hFD)});
      cyc;
      #1;
      check("fair_rsp", {21'd0, rsp_valid, rsp_id, rsp_of, rsp_result},
            k[0] ? {21'd0, 1'b1, 1'b1, 1'b1, 8'h80} : {21'd0, 1'b1, 1'b0, 1'b0, 8'hF1});
      cyc;
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("idle_no_valid", {30'd0, req1_ready, req0_ready}, 32'd0);

    // Lone requesters, including back-to-back grants to req1.
    single_op(1'b0, 8'd42, 8'd4, 1'b0, 8'hA8, 1'b0);
    single_op(1'b1, 8'd2, 8'd76, 1'b0, 8'd152, 1'b0);
    single_op(1'b1, 8'd128, 8'd4, 1'b0, 8'h00, 1'b1);

    // Backpressure: hold the response for 5 cycles while req0 waits.
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op1 = 8'd2; req1_op2 = 8'd76; req1_signed = 1'b0;
    #1;
    check("bp_grant1", {30'd0, req1_ready, req0_ready}, 32'd2);
    cyc;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op1 = 8'd42; req0_op2 = 8'd4; req0_signed = 1'b0;
    #1;
    check("bp_issue_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
    cyc;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold", {19'd0, req1_ready, req0_ready, rsp_valid, rsp_id, rsp_of, rsp_result},
            {19'd0, 2'b00, 1'b1, 1'b1, 1'b0, 8'd152});
      cyc;
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_no_grant", {29'd0, rsp_valid, req1_ready, req0_ready}, 32'd4);
    cyc;
    #1;
    check("bp_next_grant", {29'd0, rsp_valid, req1_ready, req0_ready}, 32'd1);
    cyc;
    req0_valid = 1'b0;
    cyc;
    #1;
    check("bp_rsp0", {21'd0, rsp_valid, rsp_id, rsp_of, rsp_result},
          {21'd0, 1'b1, 1'b0, 1'b0, 8'hA8});
    cyc;

    // SETTLE=4 latency: ISSUE lasts exactly 4 cycles.
    s4_req1_valid = 1'b1; s4_req1_op1 = 8'd2; s4_req1_op2 = 8'd76; s4_req1_signed = 1'b0;
    #1;
    check("s4_grant", {30'd0, s4_req1_ready, s4_req0_ready}, 32'd2);
    cyc;
    s4_req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("s4_settle", {31'd0, s4_rsp_valid}, 32'd0);
      cyc;
    end
    #1;
    check("s4_rsp", {21'd0, s4_rsp_valid, s4_rsp_id, s4_rsp_of, s4_rsp_result},
          {21'd0, 1'b1, 1'b1, 1'b0, 8'd152});
    cyc;

    // Reset during ISSUE with req1 still pending alone.
    s4_req1_valid = 1'b1; s4_req1_op1 = 8'd3; s4_req1_op2 = 8'd5;
    #1;
    check("s4_grant_a", {30'd0, s4_req1_ready, s4_req0_ready}, 32'd2);
    cyc;
    cyc;
    s4_rst_n = 1'b0;
    #1;
    check("s4_rst_outputs",
          {9'd0, s4_mult_op1, s4_mult_op2, s4_mult_signed, s4_rsp_valid, s4_rsp_id,
           s4_rsp_of, s4_req1_ready, s4_req0_ready, s4_rsp_result[1:0]}, 32'd0);
    check("s4_rst_result", {24'd0, s4_rsp_result}, 32'd0);
    cyc;
    s4_rst_n = 1'b1;
    #1;
    check("s4_after_rst_lone", {29'd0, s4_rsp_valid, s4_req1_ready, s4_req0_ready}, 32'd2);
    cyc;
    // Reset again in ISSUE, this time with both requesters pending.
    s4_req0_valid = 1'b1; s4_req0_op1 = 8'hFD; s4_req0_op2 = 8'h05; s4_req0_signed = 1'b1;
    #1;
    check("s4_issue_b", {30'd0, s4_req1_ready, s4_req0_ready}, 32'd0);
    cyc;
    s4_rst_n = 1'b0;
    #1;
    check("s4_rst_b", {23'd0, s4_rsp_valid, s4_mult_op1}, 32'd0);
    cyc;
    s4_rst_n = 1'b1;
    #1;
    check("s4_after_rst_both", {30'd0, s4_req1_ready, s4_req0_ready}, 32'd1);
    cyc;
    s4_req0_valid = 1'b0;
    s4_req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("s4_settle_b", {31'd0, s4_rsp_valid}, 32'd0);
      cyc;
    end
    cyc;
    #1;
    check("s4_rsp_b", {21'd0, s4_rsp_valid, s4_rsp_id, s4_rsp_of, s4_rsp_result},
          {21'd0, 1'b1, 1'b0, 1'b0, 8'hF1});
    cyc;

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one combinational 8-bit integer multiplier between two requesters.
- The multiplier is either the team's unsigned_mult or its signed counterpart, selected by mult_signed.
- Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
- Operands are latched, driven to the multiplier for a programmable settle time, then the product and overflow are captured and returned tagged with the requester id.

Parameters:
- WIDTH, 8, operand/result width; matches the multiplier datapath.
- SETTLE, 1, cycles operands are held on the multiplier before capture; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op1  in  WIDTH  requester 0 operand 1.
- req0_op2  in  WIDTH  requester 0 operand 2.
- req0_signed  in  1  requester 0: 1 = two's-complement multiply, 0 = unsigned.
- req1_valid, req1_ready, req1_op1, req1_op2, req1_signed  same as requester 0, for requester 1.
- mult_op1  out  WIDTH  operand 1 to the shared multiplier.
- mult_op2  out  WIDTH  operand 2 to the shared multiplier.
- mult_signed  out  1  selects signed or unsigned multiplier result.
- mult_result  in  WIDTH  multiplier product, truncated to WIDTH.
- mult_of  in  1  multiplier overflow flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester id of the response.
- rsp_result  out  WIDTH  captured product.
- rsp_of  out  1  captured overflow flag.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state = IDLE; the in-flight operation is discarded and no response is produced.
  - mult_op1, mult_op2, mult_signed, rsp_valid, rsp_id, rsp_result, rsp_of = 0.
  - Settle counter = 0; last_grant = 1, so requester 0 wins the first contention.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - grant = the sole valid requester. If both are valid, grant = !last_grant.
  - reqN_ready = (state==IDLE) & grant==N; combinational, high for exactly one cycle.
  - On the accepting edge:
    - latch opN_1 → mult_op1, opN_2 → mult_op2, reqN_signed → mult_signed.
    - record id; last_grant = N; counter = SETTLE; go to ISSUE.
  - No valid requester: remain in IDLE, all readies low.
- ISSUE:
  - mult_* outputs are held stable.
  - Counter decrements each cycle; state is occupied for exactly SETTLE cycles.
  - On the edge where counter==1: capture mult_result → rsp_result and mult_of → rsp_of; set rsp_id and rsp_valid=1; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_* held stable until rsp_ready=1 is sampled.
  - On handshake: rsp_valid = 0, go to IDLE. The next grant is possible the cycle after the handshake.
  - mult_* outputs keep their last value; they are not cleared.
- Both readies are low in ISSUE and RESP. A requester must hold valid and operands stable until its ready is seen. Dropping valid before ready is legal and simply withdraws the request.
- Throughput: at most one operation per SETTLE+2 cycles with rsp_ready tied high.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…
- A lone requester may win back-to-back grants.
- Width rules:
  - Result is whatever the multiplier presents, i.e. the low WIDTH bits.
  - The arbiter performs no arithmetic and never modifies result or overflow.
- rsp_ready asserted outside RESP is ignored.

Test Plan:
- Each case below runs with SETTLE=1 and the bench's multiplier model muxed by mult_signed, unless stated otherwise.
- req0 only, 42×4 unsigned, rsp_ready=1 → req0_ready at cycle 0; rsp_valid 2 cycles later; rsp_id=0, rsp_result=168 (0xA8), rsp_of=0.
- req1 only, 2×76 unsigned then 128×4 unsigned → first rsp_result=152, rsp_of=0; second rsp_result=0x00, rsp_of=1. Both rsp_id=1, back-to-back grants.
- Both requesters valid continuously from reset, req0: −3×5 signed (0xFD×0x05), req1: 64×2 signed:
  - Grant order is 0,1,0,1.
  - req0 responses: rsp_result=0xF1, rsp_of=0.
  - req1 responses: rsp_result=0x80, rsp_of=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_* stable; both readies low; no new grant until the cycle after rsp_ready=1.
- rst_n pulsed low during ISSUE with SETTLE=4 → all outputs 0 immediately, no response emitted. After release, the pending req1 is granted if alone, or req0 wins if both are valid.
